// File: rtl/difftest_multicore_endpoint_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : difftest_multicore_endpoint_pkg
//  Purpose  : Shared status encoding, exit-code constant and sizing helper
//             for the multi-core difftest endpoint.
//  Revision : 1.0  initial release
// ============================================================================
package difftest_multicore_endpoint_pkg;

  localparam int STATUS_W = 3;

  // Run status. ST_RUN is the only non-terminal state.
  typedef enum logic [STATUS_W-1:0] {
    ST_RUN     = 3'd0,
    ST_DONE    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_STUCK   = 3'd3,
    ST_TIMEOUT = 3'd4
  } status_e;

  // A core reports a clean exit by driving all ones on its exit channel.
  localparam logic [63:0] EXIT_GOOD = 64'hFFFF_FFFF_FFFF_FFFF;

  // Width of a core index; a single-core build still gets a 1-bit field.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/difftest_multicore_endpoint_if.sv
`default_nettype none
// ============================================================================
//  Module   : difftest_multicore_endpoint_if
//  Purpose  : Per-core UART input channels and the merged UART output
//             channel of the difftest endpoint (valid/ready handshakes).
//  Revision : 1.0  initial release
// ============================================================================
interface difftest_multicore_endpoint_if #(
  parameter int NUM_CORES = 2
) ();
  logic [NUM_CORES-1:0]   uart_in_valid;
  logic [NUM_CORES*8-1:0] uart_in_ch;
  logic [NUM_CORES-1:0]   uart_in_ready;
  logic                   uart_out_valid;
  logic [7:0]             uart_out_ch;
  logic                   uart_out_ready;

  // Endpoint side: consumes per-core chars, produces the merged stream.
  modport slave (
    input  uart_in_valid, uart_in_ch, uart_out_ready,
    output uart_in_ready, uart_out_valid, uart_out_ch
  );

  // Core/host side.
  modport master (
    output uart_in_valid, uart_in_ch, uart_out_ready,
    input  uart_in_ready, uart_out_valid, uart_out_ch
  );
endinterface
`default_nettype wire

// File: rtl/difftest_multicore_endpoint_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : difftest_sync_fifo
//  Purpose  : Single-clock FIFO with pointer+count bookkeeping. A push into
//             a full FIFO is dropped; push and pop may occur together.
//  Revision : 1.0  initial release
// ============================================================================
module difftest_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr];

  // Storage is not reset: emptiness is tracked by the count alone.
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/difftest_multicore_endpoint.sv
`default_nettype none
// ============================================================================
//  Module   : difftest_multicore_endpoint
//  Purpose  : Watches NUM_CORES difftest step/exit channels, runs cycle and
//             stuck watchdogs, keeps one sticky run status and merges the
//             per-core UART streams round-robin into a buffered output.
//  Revision : 1.0  initial release
// ============================================================================
module difftest_multicore_endpoint
  import difftest_multicore_endpoint_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int STEP_W     = 8,
  parameter int CYC_W      = 64,
  parameter int UART_DEPTH = 16,
  localparam int SC_W      = sel_w(NUM_CORES)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CYC_W-1:0]            max_cycles,
  input  logic [CYC_W-1:0]            stuck_limit,
  input  logic [NUM_CORES*STEP_W-1:0] core_step,
  input  logic [NUM_CORES*64-1:0]     core_exit,
  difftest_multicore_endpoint_if.slave uart,
  input  logic                        perf_clean_req,
  output logic                        perf_clean,
  output logic                        perf_dump,
  output logic [STATUS_W-1:0]         status,
  output logic [SC_W-1:0]             status_core,
  output logic [63:0]                 exit_code,
  output logic [CYC_W-1:0]            n_cycles
);

  status_e          r_status;
  logic [SC_W-1:0]  r_status_core;
  logic [63:0]      r_exit_code;
  logic [CYC_W-1:0] r_n_cycles;
  logic             r_perf_dump;
  logic             r_perf_clean;
  logic             r_clean_req_d;
  logic [SC_W-1:0]  r_rr_ptr;

  logic [NUM_CORES-1:0] w_fin_now;
  logic [NUM_CORES-1:0] w_exit_bad;
  logic [NUM_CORES-1:0] w_stuck_hit;
  logic                 w_fail_any,  w_stuck_any;
  logic [SC_W-1:0]      w_fail_idx,  w_stuck_idx;
  logic [63:0]          w_fail_code;
  logic                 w_timeout,   w_done;

  // Per-core watchdog state lives with its core's slice of the inputs.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    logic [63:0]      w_exit;
    logic             w_stepped;
    logic             w_good;
    logic             r_finished;
    logic [CYC_W-1:0] r_stuck_timer;

    assign w_exit          = core_exit[gi*64 +: 64];
    assign w_stepped       = |core_step[gi*STEP_W +: STEP_W];
    assign w_good          = (w_exit == EXIT_GOOD);
    assign w_fin_now[gi]   = r_finished | w_good;
    assign w_exit_bad[gi]  = !r_finished && (w_exit != 64'd0) && !w_good;
    assign w_stuck_hit[gi] = (stuck_limit != '0) && !w_fin_now[gi] &&
                             (r_stuck_timer >= stuck_limit);

    // Sticky finish flag and saturating no-progress timer.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_finished    <= 1'b0;
        r_stuck_timer <= '0;
      end else begin
        if (w_good) r_finished <= 1'b1;
        if (w_stepped || w_fin_now[gi])  r_stuck_timer <= '0;
        else if (r_stuck_timer != '1)    r_stuck_timer <= r_stuck_timer + 1'b1;
      end
    end
  end

  // Lowest-index offender wins for both FAIL and STUCK.
  always_comb begin
    w_fail_any  = 1'b0;
    w_fail_idx  = '0;
    w_stuck_any = 1'b0;
    w_stuck_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_exit_bad[i]) begin
        w_fail_any = 1'b1;
        w_fail_idx = SC_W'(i);
      end
      if (w_stuck_hit[i]) begin
        w_stuck_any = 1'b1;
        w_stuck_idx = SC_W'(i);
      end
    end
  end

  assign w_fail_code = core_exit[w_fail_idx*64 +: 64];
  assign w_timeout   = (max_cycles != '0) && (r_n_cycles >= max_cycles);
  assign w_done      = &w_fin_now;

  // Status FSM: the cycle counter stops on the cycle a terminal state is
  // taken, so it reads the last cycle spent running.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_status      <= ST_RUN;
      r_status_core <= '0;
      r_exit_code   <= '0;
      r_n_cycles    <= '0;
      r_perf_dump   <= 1'b0;
    end else begin
      r_perf_dump <= 1'b0;
      if (r_status == ST_RUN) begin
        if (w_fail_any) begin
          r_status      <= ST_FAIL;
          r_status_core <= w_fail_idx;
          r_exit_code   <= w_fail_code;
          r_perf_dump   <= 1'b1;
        end else if (w_stuck_any) begin
          r_status      <= ST_STUCK;
          r_status_core <= w_stuck_idx;
          r_perf_dump   <= 1'b1;
        end else if (w_timeout) begin
          r_status      <= ST_TIMEOUT;
          r_perf_dump   <= 1'b1;
        end else if (w_done) begin
          r_status      <= ST_DONE;
          r_perf_dump   <= 1'b1;
        end else if (r_n_cycles != '1) begin
          r_n_cycles    <= r_n_cycles + 1'b1;
        end
      end
    end
  end

  // One clear pulse per rising edge of the request, only while running.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clean_req_d <= 1'b0;
      r_perf_clean  <= 1'b0;
    end else begin
      r_clean_req_d <= perf_clean_req;
      r_perf_clean  <= perf_clean_req && !r_clean_req_d && (r_status == ST_RUN);
    end
  end

  // UART round-robin: prefer the lowest valid core at/after the pointer,
  // otherwise wrap to the lowest valid core overall.
  logic                 w_hi_any, w_lo_any;
  logic [SC_W-1:0]      w_hi_idx, w_lo_idx, w_grant_idx;
  logic                 w_grant_any;
  logic [NUM_CORES-1:0] w_ready;
  logic                 w_fifo_full, w_fifo_empty;
  logic [7:0]           w_fifo_dout;

  always_comb begin
    w_hi_any = 1'b0;
    w_hi_idx = '0;
    w_lo_any = 1'b0;
    w_lo_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (uart.uart_in_valid[i]) begin
        w_lo_any = 1'b1;
        w_lo_idx = SC_W'(i);
        if (SC_W'(i) >= r_rr_ptr) begin
          w_hi_any = 1'b1;
          w_hi_idx = SC_W'(i);
        end
      end
    end
  end

  assign w_grant_idx = w_hi_any ? w_hi_idx : w_lo_idx;
  assign w_grant_any = w_lo_any && !w_fifo_full;

  // One-hot ready towards the granted core.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_ready[i] = w_grant_any && (w_grant_idx == SC_W'(i));
    end
  end

  // Pointer moves past the core that was just served.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_grant_any) begin
      r_rr_ptr <= (w_grant_idx == SC_W'(NUM_CORES - 1)) ? '0 : w_grant_idx + 1'b1;
    end
  end

  difftest_sync_fifo #(
    .WIDTH (8),
    .DEPTH (UART_DEPTH)
  ) u_uart_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_grant_any),
    .push_data (uart.uart_in_ch[w_grant_idx*8 +: 8]),
    .full      (w_fifo_full),
    .pop       (uart.uart_out_ready),
    .pop_data  (w_fifo_dout),
    .empty     (w_fifo_empty)
  );

  assign uart.uart_in_ready  = w_ready;
  assign uart.uart_out_valid = !w_fifo_empty;
  assign uart.uart_out_ch    = w_fifo_dout;

  assign status      = r_status;
  assign status_core = r_status_core;
  assign exit_code   = r_exit_code;
  assign n_cycles    = r_n_cycles;
  assign perf_dump   = r_perf_dump;
  assign perf_clean  = r_perf_clean;

endmodule
`default_nettype wire

// File: tb/tb_difftest_multicore_endpoint.sv
`default_nettype none
// ============================================================================
//  Module   : tb_difftest_multicore_endpoint
//  Purpose  : Self-checking bench: reference model of the endpoint compared
//             every cycle, plus directed scenarios with literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_difftest_multicore_endpoint;
  import difftest_multicore_endpoint_pkg::*;

  localparam int NC    = 2;
  localparam int DEPTH = 16;
  localparam logic [63:0] GOOD = 64'hFFFF_FFFF_FFFF_FFFF;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [63:0]    max_cycles = '0;
  logic [63:0]    stuck_limit = '0;
  logic [NC*8-1:0]  core_step = '0;
  logic [NC*64-1:0] core_exit = '0;
  logic           perf_clean_req = 1'b0;
  logic           perf_clean, perf_dump;
  logic [2:0]     status;
  logic [0:0]     status_core;
  logic [63:0]    exit_code;
  logic [63:0]    n_cycles;

  difftest_multicore_endpoint_if #(.NUM_CORES(NC)) u_if ();

  difftest_multicore_endpoint #(
    .NUM_CORES(NC), .STEP_W(8), .CYC_W(64), .UART_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .max_cycles(max_cycles), .stuck_limit(stuck_limit),
    .core_step(core_step), .core_exit(core_exit),
    .uart(u_if),
    .perf_clean_req(perf_clean_req), .perf_clean(perf_clean), .perf_dump(perf_dump),
    .status(status), .status_core(status_core), .exit_code(exit_code), .n_cycles(n_cycles)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_live = 0;
  status_e     m_status = ST_RUN;
  logic [63:0] m_n = '0;
  int          m_core = 0;
  logic [63:0] m_code = '0;
  bit          m_dump = 0, m_clean = 0, m_prev_req = 0;
  bit [NC-1:0] m_fin = '0;
  logic [63:0] m_timer [NC];
  logic [7:0]  m_fifo [$];
  int          m_ptr = 0;

  // Round-robin grant: first valid core scanning from the pointer, if room.
  function automatic int model_grant();
    if (m_fifo.size() >= DEPTH) return -1;
    for (int k = 0; k < NC; k++) begin
      int c = (m_ptr + k) % NC;
      if (u_if.uart_in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    int fail_i, stuck_i, g;
    bit all_fin, was_run;
    bit [NC-1:0] fin_now;
    logic [63:0] ex;
    if (reset) begin
      m_live = 1; m_status = ST_RUN; m_n = '0; m_core = 0; m_code = '0;
      m_dump = 0; m_clean = 0; m_prev_req = 0; m_fin = '0; m_ptr = 0;
      for (int i = 0; i < NC; i++) m_timer[i] = '0;
      m_fifo.delete();
      return;
    end
    g = model_grant();
    was_run = (m_status == ST_RUN);
    fail_i = -1; stuck_i = -1; all_fin = 1;
    for (int i = 0; i < NC; i++) begin
      ex = core_exit[i*64 +: 64];
      fin_now[i] = m_fin[i] || (ex == GOOD);
      if (!fin_now[i]) all_fin = 0;
      if (fail_i < 0 && !m_fin[i] && ex != 0 && ex != GOOD) fail_i = i;
      if (stuck_i < 0 && stuck_limit != 0 && !fin_now[i] && m_timer[i] >= stuck_limit) stuck_i = i;
    end
    m_dump = 0;
    if (was_run) begin
      if (fail_i >= 0) begin
        m_status = ST_FAIL; m_core = fail_i; m_code = core_exit[fail_i*64 +: 64]; m_dump = 1;
      end else if (stuck_i >= 0) begin
        m_status = ST_STUCK; m_core = stuck_i; m_dump = 1;
      end else if (max_cycles != 0 && m_n >= max_cycles) begin
        m_status = ST_TIMEOUT; m_dump = 1;
      end else if (all_fin) begin
        m_status = ST_DONE; m_dump = 1;
      end else if (m_n != GOOD) begin
        m_n = m_n + 1;
      end
    end
    m_clean = perf_clean_req && !m_prev_req && was_run;
    m_prev_req = perf_clean_req;
    for (int i = 0; i < NC; i++) begin
      if (core_step[i*8 +: 8] != 0 || fin_now[i]) m_timer[i] = '0;
      else if (m_timer[i] != GOOD) m_timer[i] = m_timer[i] + 1;
    end
    m_fin = m_fin | fin_now;
    if (m_fifo.size() > 0 && u_if.uart_out_ready) void'(m_fifo.pop_front());
    if (g >= 0) begin
      m_fifo.push_back(u_if.uart_in_ch[g*8 +: 8]);
      m_ptr = (g + 1) % NC;
    end
  endtask

  task automatic compare_all();
    int g;
    logic [NC-1:0] er;
    g = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("status",      64'(status),      64'(m_status));
    check("n_cycles",    n_cycles,         m_n);
    check("status_core", 64'(status_core), 64'(m_core));
    check("exit_code",   exit_code,        m_code);
    check("perf_dump",   64'(perf_dump),   64'(m_dump));
    check("perf_clean",  64'(perf_clean),  64'(m_clean));
    check("uart_out_valid", 64'(u_if.uart_out_valid), 64'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) check("uart_out_ch", 64'(u_if.uart_out_ch), 64'(m_fifo[0]));
    check("uart_in_ready", 64'(u_if.uart_in_ready), 64'(er));
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (m_live) compare_all();
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    core_exit = '0;
    core_step = '0;
    perf_clean_req = 1'b0;
    u_if.uart_in_valid = '0;
    u_if.uart_in_ch = '0;
    u_if.uart_out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int acc [NC];
    int seq [$];
    logic [7:0] outq [$];
    logic [NC-1:0] rdy;
    int mism, total;
    logic [7:0] ec;

    u_if.uart_in_valid = '0;
    u_if.uart_in_ch = '0;
    u_if.uart_out_ready = 1'b0;

    // T1: core0 good at 10, core1 good at 25 -> DONE visible at 26
    max_cycles = 0; stuck_limit = 0;
    do_reset();
    check("t1_reset_status", 64'(status), 64'(ST_RUN));
    check("t1_reset_n", n_cycles, 64'd0);
    core_step = {8'd1, 8'd1};
    for (int c = 0; c <= 32; c++) begin
      core_exit[63:0]   = (c >= 10) ? GOOD : 64'd0;
      core_exit[127:64] = (c >= 25) ? GOOD : 64'd0;
      perf_clean_req = (c >= 3 && c <= 6) || (c >= 30);
      @(negedge clock);
      if (c == 4)  check("t1_clean_pulse", 64'(perf_clean), 64'd1);
      if (c == 5)  check("t1_clean_once", 64'(perf_clean), 64'd0);
      if (c == 25) check("t1_run_at_25", 64'(status), 64'(ST_RUN));
      if (c == 25) check("t1_no_dump_25", 64'(perf_dump), 64'd0);
      if (c == 26) begin
        check("t1_done_at_26", 64'(status), 64'(ST_DONE));
        check("t1_dump_at_26", 64'(perf_dump), 64'd1);
        check("t1_n_frozen", n_cycles, 64'd25);
      end
      if (c == 27) check("t1_dump_once", 64'(perf_dump), 64'd0);
      if (c == 31) check("t1_clean_ignored", 64'(perf_clean), 64'd0);
      tick();
    end

    // T2: core1 bad exit and core0 stuck in the same cycle -> FAIL wins
    max_cycles = 0; stuck_limit = 20;
    do_reset();
    core_step = {8'd1, 8'd0};
    for (int c = 0; c <= 22; c++) begin
      core_exit[127:64] = (c >= 20) ? 64'd5 : 64'd0;
      @(negedge clock);
      if (c == 20) check("t2_run_at_20", 64'(status), 64'(ST_RUN));
      if (c == 21) begin
        check("t2_fail", 64'(status), 64'(ST_FAIL));
        check("t2_core", 64'(status_core), 64'd1);
        check("t2_code", exit_code, 64'd5);
      end
      tick();
    end

    // T3: core1 never steps, limit 100 -> STUCK at cycle 101
    max_cycles = 0; stuck_limit = 100;
    do_reset();
    core_step = {8'd0, 8'd3};
    for (int c = 0; c <= 102; c++) begin
      @(negedge clock);
      if (c == 100) check("t3_run_at_100", 64'(status), 64'(ST_RUN));
      if (c == 101) begin
        check("t3_stuck", 64'(status), 64'(ST_STUCK));
        check("t3_core", 64'(status_core), 64'd1);
        check("t3_n", n_cycles, 64'd100);
        check("t3_code", exit_code, 64'd0);
      end
      tick();
    end

    // T4: max_cycles=50 -> TIMEOUT, counter frozen at 50; then unlimited
    max_cycles = 50; stuck_limit = 0;
    do_reset();
    for (int c = 0; c <= 60; c++) begin
      @(negedge clock);
      if (c == 50) check("t4_run_at_50", 64'(status), 64'(ST_RUN));
      if (c == 51) check("t4_timeout", 64'(status), 64'(ST_TIMEOUT));
      if (c == 60) check("t4_n_frozen", n_cycles, 64'd50);
      tick();
    end
    max_cycles = 0;
    do_reset();
    for (int c = 0; c <= 200; c++) begin
      @(negedge clock);
      if (c == 200) begin
        check("t4_unlimited_run", 64'(status), 64'(ST_RUN));
        check("t4_unlimited_n", n_cycles, 64'd200);
      end
      tick();
    end

    // T5: two streams into a blocked output, then drain
    max_cycles = 0; stuck_limit = 0;
    do_reset();
    core_step = {8'd1, 8'd1};
    acc[0] = 0; acc[1] = 0;
    rdy = '0;
    for (int c = 0; c < 24; c++) begin
      u_if.uart_in_valid = 2'b11;
      u_if.uart_in_ch = {8'(8'h61 + acc[1]), 8'(8'h41 + acc[0])};
      @(negedge clock);
      rdy = u_if.uart_in_ready;
      tick();
      for (int i = 0; i < NC; i++) if (rdy[i]) begin acc[i]++; seq.push_back(i); end
    end
    check("t5_accepted", 64'(seq.size()), 64'd16);
    if (seq.size() >= 16) begin
      check("t5_seq0", 64'(seq[0]), 64'd0);
      check("t5_seq1", 64'(seq[1]), 64'd1);
      check("t5_seq15", 64'(seq[15]), 64'd1);
    end
    check("t5_ready_blocked", 64'(rdy), 64'd0);
    u_if.uart_out_ready = 1'b1;
    for (int c = 0; c < 60 && outq.size() < 20; c++) begin
      u_if.uart_in_ch = {8'(8'h61 + acc[1]), 8'(8'h41 + acc[0])};
      @(negedge clock);
      rdy = u_if.uart_in_ready;
      if (u_if.uart_out_valid) outq.push_back(u_if.uart_out_ch);
      tick();
      for (int i = 0; i < NC; i++) if (rdy[i]) acc[i]++;
    end
    check("t5_drained", 64'(outq.size()), 64'd20);
    mism = 0;
    for (int j = 0; j < outq.size(); j++) begin
      ec = (j % 2 == 0) ? 8'(8'h41 + j / 2) : 8'(8'h61 + j / 2);
      if (outq[j] !== ec) mism++;
    end
    check("t5_order_errors", 64'(mism), 64'd0);
    if (outq.size() >= 18) begin
      check("t5_first", 64'(outq[0]), 64'h41);
      check("t5_resume0", 64'(outq[16]), 64'h49);
      check("t5_resume1", 64'(outq[17]), 64'h69);
    end
    u_if.uart_in_valid = '0;

    // T6: reset with FIFO half full flushes everything
    do_reset();
    core_step = {8'd1, 8'd1};
    acc[0] = 0; acc[1] = 0;
    for (int c = 0; c < 20; c++) begin
      total = acc[0] + acc[1];
      u_if.uart_in_valid = (total < 8) ? 2'b11 : 2'b00;
      u_if.uart_in_ch = {8'(8'h30 + acc[1]), 8'(8'h50 + acc[0])};
      @(negedge clock);
      rdy = u_if.uart_in_ready;
      tick();
      for (int i = 0; i < NC; i++) if (rdy[i]) acc[i]++;
    end
    check("t6_half_full", 64'(acc[0] + acc[1]), 64'd8);
    check("t6_valid_before", 64'(u_if.uart_out_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("t6_empty_after", 64'(u_if.uart_out_valid), 64'd0);
    check("t6_status", 64'(status), 64'(ST_RUN));
    check("t6_n", n_cycles, 64'd0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
